// File: rtl/noc_pkg.sv
// Shared mesh packet definitions: field positions, packet width and packed layout
// used by both the router switches and the transmit-side packetizer.
package noc_pkg;

    localparam int PKT_WIDTH    = 39;

    localparam int FLD_TYPE_MSB = 38;
    localparam int FLD_TYPE_LSB = 37;
    localparam int FLD_X_MSB    = 36;
    localparam int FLD_X_LSB    = 33;
    localparam int FLD_Y_MSB    = 32;
    localparam int FLD_Y_LSB    = 29;
    localparam int FLD_CNT_MSB  = 28;
    localparam int FLD_CNT_LSB  = 27;
    localparam int FLD_SEQ_MSB  = 26;
    localparam int FLD_SEQ_LSB  = 24;
    localparam int FLD_B0_MSB   = 23;
    localparam int FLD_B0_LSB   = 16;
    localparam int FLD_B1_MSB   = 15;
    localparam int FLD_B1_LSB   = 8;
    localparam int FLD_B2_MSB   = 7;
    localparam int FLD_B2_LSB   = 0;

    typedef struct packed {
        logic [1:0] pkt_type;
        logic [3:0] dst_x;
        logic [3:0] dst_y;
        logic [1:0] count;
        logic [2:0] seq;
        logic [7:0] byte0;
        logic [7:0] byte1;
        logic [7:0] byte2;
    } noc_pkt_t;

    function automatic noc_pkt_t noc_pack(
        input logic [1:0] ptype,
        input logic [3:0] dx,
        input logic [3:0] dy,
        input logic [1:0] cnt,
        input logic [2:0] seq,
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2
    );
        noc_pkt_t p;
        p.pkt_type = ptype;
        p.dst_x    = dx;
        p.dst_y    = dy;
        p.count    = cnt;
        p.seq      = seq;
        p.byte0    = b0;
        p.byte1    = b1;
        p.byte2    = b2;
        return p;
    endfunction

endpackage

// File: rtl/noc_packetizer.sv
// Gathers up to three payload bytes plus a destination into one mesh packet and offers it
// on a valid/ready port; self-addressed packets are dropped. Optional macro: NOC_PACKETIZER_SEQ_EN.
module noc_packetizer
    import noc_pkg::*;
#(
    parameter int         WIDTH    = PKT_WIDTH,
    parameter logic [3:0] X_LOCAL  = 4'b0000,
    parameter logic [3:0] Y_LOCAL  = 4'b0001,
    parameter logic [1:0] PKT_TYPE = 2'b01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    input  logic [3:0]       dst_x,
    input  logic [3:0]       dst_y,
    output logic             pkt_valid,
    input  logic             pkt_ready,
    output logic [WIDTH-1:0] pkt_data,
    output logic             err_self
);

    typedef enum logic [1:0] {B0 = 2'd0, B1 = 2'd1, B2 = 2'd2, SEND = 2'd3} noc_pktz_state_e;

    noc_pktz_state_e  r_state;
    noc_pktz_state_e  w_next_state;
    logic [7:0]       r_byte0;
    logic [7:0]       r_byte1;
    logic [3:0]       r_dst_x;
    logic [3:0]       r_dst_y;
    logic [WIDTH-1:0] r_pkt_data;
    logic             r_err_self;
    logic             w_in_ready;
    logic             w_pkt_valid;
    logic             w_in_fire;
    logic             w_pkt_fire;
    logic             w_complete;
    logic             w_self;
    logic [3:0]       w_dst_x;
    logic [3:0]       w_dst_y;
    logic [1:0]       w_count;
    logic [7:0]       w_b0;
    logic [7:0]       w_b1;
    logic [7:0]       w_b2;
    logic [2:0]       w_seq;
    noc_pkt_t         w_pkt;

    assign w_in_fire  = in_valid && w_in_ready;
    assign w_pkt_fire = w_pkt_valid && pkt_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= B0;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a completing self-addressed packet returns straight to B0
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            B0:      if (w_in_fire) w_next_state = in_last ? (w_self ? B0 : SEND) : B1;
                     else           w_next_state = B0;
            B1:      if (w_in_fire) w_next_state = in_last ? (w_self ? B0 : SEND) : B2;
                     else           w_next_state = B1;
            B2:      if (w_in_fire) w_next_state = w_self ? B0 : SEND;
                     else           w_next_state = B2;
            SEND:    if (w_pkt_ready_ok()) w_next_state = B0;
                     else                  w_next_state = SEND;
            default: w_next_state = B0;
        endcase
    end

    function automatic logic w_pkt_ready_ok();
        return pkt_ready;
    endfunction

    // Handshake outputs decoded from the state register
    always_comb begin
        w_in_ready  = 1'b0;
        w_pkt_valid = 1'b0;
        unique case (r_state)
            B0, B1, B2: w_in_ready  = 1'b1;
            SEND:       w_pkt_valid = 1'b1;
            default:    w_in_ready  = 1'b0;
        endcase
    end

    // Packet image as it would look if the byte offered this cycle completed it
    always_comb begin
        w_dst_x    = r_dst_x;
        w_dst_y    = r_dst_y;
        w_b0       = r_byte0;
        w_b1       = r_byte1;
        w_b2       = 8'h00;
        w_count    = 2'd0;
        w_complete = 1'b0;
        unique case (r_state)
            B0: begin
                w_dst_x    = dst_x;
                w_dst_y    = dst_y;
                w_b0       = in_data;
                w_b1       = 8'h00;
                w_count    = 2'd1;
                w_complete = w_in_fire && in_last;
            end
            B1: begin
                w_b1       = in_data;
                w_count    = 2'd2;
                w_complete = w_in_fire && in_last;
            end
            B2: begin
                w_b2       = in_data;
                w_count    = 2'd3;
                w_complete = w_in_fire;
            end
            default: w_complete = 1'b0;
        endcase
    end

    assign w_self = (w_dst_x == X_LOCAL) && (w_dst_y == Y_LOCAL);
    assign w_pkt  = noc_pack(PKT_TYPE, w_dst_x, w_dst_y, w_count, w_seq, w_b0, w_b1, w_b2);

    // Byte slots and destination capture; slots are cleared whenever a packet ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte0 <= 8'h00;
            r_byte1 <= 8'h00;
            r_dst_x <= 4'h0;
            r_dst_y <= 4'h0;
        end else if (w_pkt_fire || (w_complete && w_self)) begin
            r_byte0 <= 8'h00;
            r_byte1 <= 8'h00;
        end else if (w_in_fire && (r_state == B0)) begin
            r_byte0 <= in_data;
            r_dst_x <= dst_x;
            r_dst_y <= dst_y;
        end else if (w_in_fire && (r_state == B1)) begin
            r_byte1 <= in_data;
        end
    end

    // Registered packet and drop pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_data <= {WIDTH{1'b0}};
            r_err_self <= 1'b0;
        end else begin
            r_err_self <= w_complete && w_self;
            if (w_complete && !w_self) begin
                r_pkt_data <= w_pkt;
            end else if (w_pkt_fire) begin
                r_pkt_data <= {WIDTH{1'b0}};
            end
        end
    end

`ifdef NOC_PACKETIZER_SEQ_EN
    logic [2:0] r_seq;

    // Sequence counter advances once per packet handed to the router
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq <= 3'd0;
        end else if (w_pkt_fire) begin
            r_seq <= r_seq + 3'd1;
        end
    end

    assign w_seq = r_seq;
`else
    assign w_seq = 3'b000;
`endif

    assign in_ready  = w_in_ready;
    assign pkt_valid = w_pkt_valid;
    assign pkt_data  = r_pkt_data;
    assign err_self  = r_err_self;

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed self-checking bench for noc_packetizer; expected packets are written out by hand
// and the sequence field expectation follows NOC_PACKETIZER_SEQ_EN.
module tb_noc_packetizer;
    import noc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic [3:0]  dst_x;
    logic [3:0]  dst_y;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [38:0] pkt_data;
    logic        err_self;

    int          checks   = 0;
    int          failures = 0;
    logic [2:0]  exp_seq  = 3'd0;
    logic [38:0] exp_pkt;

    noc_packetizer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .dst_x(dst_x), .dst_y(dst_y),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
        .err_self(err_self)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l,
                         input logic [3:0] x, input logic [3:0] y);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        dst_x    = x;
        dst_y    = y;
    endtask

    task automatic bump_seq();
`ifdef NOC_PACKETIZER_SEQ_EN
        exp_seq = exp_seq + 3'd1;
`else
        exp_seq = 3'd0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pkt_ready = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0);
        tick(); tick();
        checks++; if (pkt_valid !== 1'b0) begin failures++; $display("FAIL reset_pkt_valid got=%b exp=0", pkt_valid); end
        checks++; if (pkt_data !== 39'd0) begin failures++; $display("FAIL reset_pkt_data got=%h exp=0", pkt_data); end
        checks++; if (err_self !== 1'b0) begin failures++; $display("FAIL reset_err_self got=%b exp=0", err_self); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        rst_n = 1'b1;
        exp_seq = 3'd0;
        tick();
    endtask

    task automatic test_seq_wrap();
        logic [2:0] want;
        pkt_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 8'(8'h10 + i), 1'b1, 4'h2, 4'h2);
            tick();
            drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0);
`ifdef NOC_PACKETIZER_SEQ_EN
            want = 3'(i % 8);
`else
            want = 3'd0;
`endif
            checks++;
            if (pkt_valid !== 1'b1 || pkt_data[FLD_SEQ_MSB:FLD_SEQ_LSB] !== want) begin
                failures++;
                $display("FAIL seq_wrap[%0d] got valid=%b seq=%0d exp valid=1 seq=%0d", i, pkt_valid, pkt_data[FLD_SEQ_MSB:FLD_SEQ_LSB], want);
            end
            tick();
            bump_seq();
        end
    endtask

    task automatic test_three_byte();
        pkt_ready = 1'b1;
        drive(1'b1, 8'h0E, 1'b0, 4'h2, 4'h3);
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL three_in_ready_b1 got=%b exp=1", in_ready); end
        drive(1'b1, 8'h05, 1'b0, 4'h9, 4'h9);
        tick();
        drive(1'b1, 8'h08, 1'b0, 4'h9, 4'h9);
        tick();
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0);
        exp_pkt = {2'b01, 4'h2, 4'h3, 2'd3, exp_seq, 8'h0E, 8'h05, 8'h08};
        checks++; if (pkt_valid !== 1'b1) begin failures++; $display("FAIL three_valid got=%b exp=1", pkt_valid); end
        checks++; if (pkt_data !== exp_pkt) begin failures++; $display("FAIL three_data got=%h exp=%h", pkt_data, exp_pkt); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL three_in_ready_send got=%b exp=0", in_ready); end
        checks++; if (err_self !== 1'b0) begin failures++; $display("FAIL three_err_self got=%b exp=0", err_self); end
        tick();
        bump_seq();
        checks++; if (pkt_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL three_after got valid=%b ready=%b exp valid=0 ready=1", pkt_valid, in_ready); end
    endtask

    task automatic test_one_byte();
        pkt_ready = 1'b1;
        drive(1'b1, 8'hAA, 1'b1, 4'h0, 4'h0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0);
        exp_pkt = {2'b01, 4'h0, 4'h0, 2'd1, exp_seq, 8'hAA, 8'h00, 8'h00};
        checks++; if (pkt_valid !== 1'b1) begin failures++; $display("FAIL one_valid got=%b exp=1", pkt_valid); end
        checks++; if (pkt_data !== exp_pkt) begin failures++; $display("FAIL one_data got=%h exp=%h", pkt_data, exp_pkt); end
        tick();
        bump_seq();
        checks++; if (pkt_valid !== 1'b0) begin failures++; $display("FAIL one_after got=%b exp=0", pkt_valid); end
    endtask

    task automatic test_backpressure();
        pkt_ready = 1'b0;
        drive(1'b1, 8'h11, 1'b0, 4'h3, 4'h4);
        tick();
        drive(1'b1, 8'h22, 1'b1, 4'h3, 4'h4);
        tick();
        drive(1'b1, 8'h77, 1'b1, 4'h5, 4'h6);
        exp_pkt = {2'b01, 4'h3, 4'h4, 2'd2, exp_seq, 8'h11, 8'h22, 8'h00};
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (pkt_valid !== 1'b1 || in_ready !== 1'b0 || pkt_data !== exp_pkt) begin
                failures++;
                $display("FAIL bp_hold[%0d] got valid=%b ready=%b data=%h exp valid=1 ready=0 data=%h", i, pkt_valid, in_ready, pkt_data, exp_pkt);
            end
            tick();
        end
        pkt_ready = 1'b1;
        checks++; if (pkt_valid !== 1'b1 || pkt_data !== exp_pkt) begin failures++; $display("FAIL bp_release got valid=%b data=%h exp valid=1 data=%h", pkt_valid, pkt_data, exp_pkt); end
        tick();
        bump_seq();
        checks++; if (pkt_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_done got valid=%b ready=%b exp valid=0 ready=1", pkt_valid, in_ready); end
        tick();
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0);
        exp_pkt = {2'b01, 4'h5, 4'h6, 2'd1, exp_seq, 8'h77, 8'h00, 8'h00};
        checks++; if (pkt_valid !== 1'b1 || pkt_data !== exp_pkt) begin failures++; $display("FAIL bp_held_byte got valid=%b data=%h exp valid=1 data=%h", pkt_valid, pkt_data, exp_pkt); end
        tick();
        bump_seq();
    endtask

    task automatic test_self_addr();
        pkt_ready = 1'b1;
        drive(1'b1, 8'h33, 1'b0, 4'h0, 4'h1);
        tick();
        checks++; if (err_self !== 1'b0) begin failures++; $display("FAIL self_early_err got=%b exp=0", err_self); end
        drive(1'b1, 8'h44, 1'b1, 4'h0, 4'h1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0);
        checks++; if (pkt_valid !== 1'b0) begin failures++; $display("FAIL self_valid got=%b exp=0", pkt_valid); end
        checks++; if (err_self !== 1'b1) begin failures++; $display("FAIL self_err_pulse got=%b exp=1", err_self); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL self_in_ready got=%b exp=1", in_ready); end
        tick();
        checks++; if (err_self !== 1'b0 || pkt_valid !== 1'b0) begin failures++; $display("FAIL self_err_end got err=%b valid=%b exp err=0 valid=0", err_self, pkt_valid); end
        drive(1'b1, 8'h55, 1'b1, 4'h1, 4'h0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0);
        exp_pkt = {2'b01, 4'h1, 4'h0, 2'd1, exp_seq, 8'h55, 8'h00, 8'h00};
        checks++; if (pkt_data !== exp_pkt || pkt_valid !== 1'b1) begin failures++; $display("FAIL self_next_pkt got valid=%b data=%h exp valid=1 data=%h", pkt_valid, pkt_data, exp_pkt); end
        tick();
        bump_seq();
    endtask

    task automatic test_reset_mid();
        pkt_ready = 1'b1;
        drive(1'b1, 8'h99, 1'b0, 4'h4, 4'h4);
        tick();
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0);
        rst_n = 1'b0;
        #2;
        checks++; if (pkt_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_state got valid=%b ready=%b exp valid=0 ready=1", pkt_valid, in_ready); end
        rst_n = 1'b1;
        exp_seq = 3'd0;
        tick();
        checks++; if (pkt_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_pkt got=%b exp=0", pkt_valid); end
        drive(1'b1, 8'hA1, 1'b0, 4'h7, 4'h2);
        tick();
        drive(1'b1, 8'hA2, 1'b0, 4'h7, 4'h2);
        tick();
        drive(1'b1, 8'hA3, 1'b1, 4'h7, 4'h2);
        tick();
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0);
        exp_pkt = {2'b01, 4'h7, 4'h2, 2'd3, 3'd0, 8'hA1, 8'hA2, 8'hA3};
        checks++; if (pkt_valid !== 1'b1 || pkt_data !== exp_pkt) begin failures++; $display("FAIL rstmid_pkt got valid=%b data=%h exp valid=1 data=%h", pkt_valid, pkt_data, exp_pkt); end
        tick();
        bump_seq();
    endtask

    initial begin
        test_reset();
        test_seq_wrap();
        test_three_byte();
        test_one_byte();
        test_backpressure();
        test_self_addr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_packetizer.md
# noc_packetizer

Clocked transmit-side network interface between a PE result stream and the local input port of its mesh router. It gathers up to three 8-bit data bytes plus a destination (x, y) into one 39-bit mesh packet, with the same field layout the router switches decode. It then presents the packet on a valid/ready output handshake. Self-addressed packets are dropped, because the router's local-input path has no route back to the local PE.

## Interface
- WIDTH, 39, packet width; fixed field map, see Operation.
- X_LOCAL, 4'b0000, this node's x coordinate.
- Y_LOCAL, 4'b0001, this node's y coordinate.
- PKT_TYPE, 2'b01, value driven on packet[38:37].

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  a byte is offered.
- in_ready  out  1  the block accepts the offered byte this cycle.
- in_data  in  8  payload byte.
- in_last  in  1  the offered byte closes the current packet.
- dst_x  in  4  destination x; sampled with the first byte of a packet only.
- dst_y  in  4  destination y; sampled with the first byte of a packet only.
- pkt_valid  out  1  pkt_data holds a complete packet.
- pkt_ready  in  1  the router local port accepts the packet.
- pkt_data  out  WIDTH  registered packet.
- err_self  out  1  one-cycle pulse when a self-addressed packet is dropped.

## Operation
- Packet field map:
  - [38:37] PKT_TYPE
  - [36:33] dst x
  - [32:29] dst y
  - [28:27] byte count (1..3)
  - [26:24] sequence number
  - [23:16] byte0
  - [15:8] byte1
  - [7:0] byte2
- Unfilled byte slots are 8'h00.
- Transfer rules: an input byte transfers when in_valid && in_ready; a packet transfers when pkt_valid && pkt_ready.
- FSM states:
  - B0: in_ready=1. On transfer, capture byte0, dst_x and dst_y. Go to SEND if in_last, else to B1.
  - B1: in_ready=1. On transfer, capture byte1. Go to SEND if in_last, else to B2.
  - B2: in_ready=1. On transfer, capture byte2. Always go to SEND; in_last is ignored here.
  - SEND: in_ready=0, pkt_valid=1.
    - On pkt_ready: go to B0, clear all byte slots, advance the sequence counter.
    - Without pkt_ready: pkt_data and pkt_valid hold unchanged, indefinitely.
- Self-addressed drop: if the captured dst equals (X_LOCAL, Y_LOCAL) at packet completion:
  - go directly to B0, never to SEND;
  - pkt_valid stays 0;
  - err_self pulses for one cycle;
  - the sequence counter does not advance.
- Sequence counter: 3 bits, counts emitted packets, wraps 7→0.
- dst_x and dst_y changes after byte0 have no effect on the current packet.

## Timing
- Reset values:
  - pkt_valid=0
  - pkt_data=0
  - err_self=0
  - in_ready=1 (state B0)
  - sequence counter 0
  - byte slots 0
- Latency: pkt_valid rises on the clock edge that accepts the completing byte and is visible the following cycle.
- Minimum period: full 3-byte packet = 3 accept cycles + 1 SEND cycle (pkt_ready held high), i.e. 4 cycles.
- 1-byte packet (in_last on byte0) = 2 cycles.
- No overlap: input is stalled in SEND even when pkt_ready=1 in the same cycle.
- in_valid with in_ready=0 holds no state; the upstream block must hold its byte.
- Reset asserted mid-packet or in SEND discards all captured bytes and any pending packet immediately (asynchronous). No packet is emitted after reset release.
- err_self is asserted on the cycle after the completing byte's accept edge and deasserts one cycle later.

## Configuration
- Macro: NOC_PACKETIZER_SEQ_EN.
- Defined: [26:24] carries the 3-bit sequence counter.
- Undefined: [26:24] is 3'b000 and no counter logic is built. All other behaviour is identical.

## Structure
- Shared package noc_pkg holds:
  - localparams for the field bit positions (type, x, y, count, seq, byte0–2);
  - PKT_WIDTH=39;
  - a packed struct typedef noc_pkt_t matching the field map.
- The switches and this block both use noc_pkg.
- FSM state enum noc_pktz_state_e (B0, B1, B2, SEND) lives locally in the module.
- No sub-module; single module.

## Test plan
- 3-byte packet, dst (2,3), bytes 0x0E,0x05,0x08, pkt_ready=1 → pkt_data = {01,0010,0011,11,000,0E,05,08}, pkt_valid high exactly 1 cycle, 4-cycle period.
- 1-byte packet, dst (0,0), byte 0xAA with in_last → count=01, byte1/byte2=00, pkt_valid appears 1 cycle after accept.
- Backpressure: pkt_ready=0 for 5 cycles in SEND → pkt_data stable, in_ready=0 throughout, then one transfer.
- Self-address: dst (0,1), 2 bytes + in_last → no pkt_valid, err_self single pulse, next packet's seq unchanged.
- With NOC_PACKETIZER_SEQ_EN: 9 consecutive packets → seq field 0..7 then 0. Without the macro → field always 000.
- Reset asserted in B1 after one byte → pkt_valid=0, in_ready=1. The next 3-byte packet carries only new bytes, seq 0.
